csa_seq_multiplier: RTL and testbench
=====================================

# csa_seq_multiplier

Parametrised sequential multiplier that computes a WIDTH×WIDTH product over WIDTH+1 clock cycles. It accumulates one partial product per cycle in carry-save form, then performs a single carry-propagate add to resolve the result. It generalises the fixed 6×6 combinational carry-save array to any operand width, adds a per-operation signed/unsigned mode, and wraps it in valid/ready handshakes so it drops into streaming datapaths.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32. Product is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair on a/b/sgn is valid.
- in_ready  output  1  block can accept operands.
  - Equals 1 only in IDLE with rst low.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- sgn  input  1  mode select: 1 = both operands two's complement; 0 = both unsigned.
- out_valid  output  1  product holds a valid result.
- out_ready  input  1  downstream accepts the product.
- product  output  2*WIDTH  registered result.

## Operation
- States: IDLE, RUN, RESOLVE, DONE. Reset state is IDLE.
- IDLE:
  - Accept when in_valid && in_ready. Capture a, b and sgn into internal registers.
  - Clear the sum and carry vectors (2*WIDTH bits each) and the bit counter. Go to RUN.
- RUN, one multiplier bit per cycle (cnt = 0..WIDTH-1):
  - Form pp = b_reg[cnt] ? (ext(a_reg) << cnt) : 0, where ext() extends a to 2*WIDTH bits: sign-extend if sgn_reg, else zero-extend.
  - Compress sum, carry and pp with a 3:2 carry-save row. New carry is the majority vector shifted left by 1, truncated to 2*WIDTH bits.
  - Signed mode, cnt = WIDTH-1 with b_reg[WIDTH-1] = 1: the MSB weight is negative. Use pp = ~(ext(a_reg) << (WIDTH-1)) and inject +1 at carry bit 0 in the same cycle.
  - After cnt = WIDTH-1, go to RESOLVE.
- RESOLVE:
  - product <= sum + carry, modulo 2^(2*WIDTH).
  - Set out_valid. Go to DONE.
- DONE:
  - Hold product and out_valid stable until out_ready = 1.
  - On the out_ready edge: out_valid <= 0, go to IDLE.
- Arithmetic contract:
  - Unsigned: product = a*b exactly.
  - Signed: product = two's-complement a*b in 2*WIDTH bits. This is exact; there is no overflow case, including (-2^(WIDTH-1))².
- While not IDLE, in_valid is ignored and a/b/sgn may change freely. There is no input buffering.
- The product register keeps its last value after handshake completion. It is overwritten only in RESOLVE.

## Timing
- Reset values: in_ready 0 while rst is high, 1 in the first cycle after release. out_valid 0. product 0. Internal state IDLE, all counters and vectors 0.
- Reset mid-operation (RUN, RESOLVE or DONE) aborts immediately and asynchronously. The operation is discarded; no partial result is ever flagged valid.
- Latency: accept edge E0. RUN occupies edges E1..E_WIDTH. RESOLVE is edge E_WIDTH+1. out_valid is high from the cycle after E_WIDTH+1.
  - This gives WIDTH+1 cycles from the accept edge to out_valid; 7 cycles for WIDTH = 6.
- Throughput with out_ready tied high: one result per WIDTH+3 cycles (accept, WIDTH RUN, RESOLVE, DONE), then back to IDLE.
- in_ready and out_valid are never high in the same cycle.
- out_ready high outside DONE has no effect.

## Test plan
- Unsigned, WIDTH=6, out_ready=1:
  - 5×3 -> product 12'h00F.
  - 63×63 -> 12'hF81.
  - 0×0 -> 12'h000.
  - Check out_valid rises exactly 7 cycles after the accept edge.
- Signed, WIDTH=6:
  - a=6'h3F, b=6'h3F (−1×−1) -> 12'h001.
  - a=b=6'h20 (−32×−32) -> 12'h400.
  - a=6'h20, b=6'h1F (−32×31) -> 12'hC20.
  - 25×19 -> 12'h1DB.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid. product must stay stable and in_ready must stay 0.
  - Drive in_valid=1 with new operands during the stall; they must be ignored.
  - Release out_ready: IDLE follows and the next operation is correct.
- Reset mid-RUN:
  - Assert rst on the 3rd RUN cycle of a 9×6 operation. out_valid and product go to 0 immediately.
  - After release, in_ready=1. A new 9×6 operation -> 12'h036.
- Parameter sweep, WIDTH=16:
  - Unsigned 65535×65535 -> 32'hFFFE0001 with 17-cycle latency.
  - Signed 16'h8000×16'h8000 -> 32'h40000000.
  - Run 1000 random operands in both modes against a behavioural reference.

Source files
------------

// File: rtl/csa_seq_multiplier.sv
// Sequential WIDTHxWIDTH multiplier: one partial product per cycle accumulated in
// carry-save form, resolved by a single carry-propagate add, with valid/ready handshakes.
module csa_seq_multiplier #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESOLVE, DONE} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic           sgn_reg;
  logic [PW-1:0]  sum, carry;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           neg_row;
  logic [PW-1:0]  a_ext, a_shift, pp, maj, csa_sum, csa_carry;

  assign accept = in_valid && in_ready;

  // One carry-save row: the current partial product is folded into sum/carry.
  // In signed mode the multiplier MSB has negative weight, so its row is
  // subtracted as ~x plus a +1 dropped into the free carry LSB.
  assign a_ext     = sgn_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
  assign a_shift   = a_ext << cnt;
  assign neg_row   = sgn_reg && (cnt == LAST) && b_reg[cnt];
  assign pp        = neg_row ? ~a_shift : (b_reg[cnt] ? a_shift : '0);
  assign csa_sum   = sum ^ carry ^ pp;
  assign maj       = (sum & carry) | (sum & pp) | (carry & pp);
  assign csa_carry = {maj[PW-2:0], neg_row};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it a missing branch would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = RESOLVE;
      RESOLVE:                   state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // NOTE: every datapath register, product included, is cleared by reset so an
  // aborted operation leaves no stale or partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      sum     <= '0;
      carry   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg   <= a;
          b_reg   <= b;
          sgn_reg <= sgn;
          sum     <= '0;
          carry   <= '0;
          cnt     <= '0;
        end
        RUN: begin
          sum   <= csa_sum;
          carry <= csa_carry;
          cnt   <= cnt + CW'(1);
        end
        RESOLVE: product <= sum + carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Directed and randomized checks of csa_seq_multiplier at WIDTH=6 and WIDTH=16.
module tb_csa_seq_multiplier;

  logic clk;
  logic rst;

  logic        iv6, ir6, s6, ov6, or6;
  logic [5:0]  a6, b6;
  logic [11:0] p6;

  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int tests  = 0;
  int failed = 0;

  csa_seq_multiplier #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .a(a6), .b(b6),
    .sgn(s6), .out_valid(ov6), .out_ready(or6), .product(p6)
  );

  csa_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sgn(s16), .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [31:0] xe, ye;
    xe = s ? {{16{x[15]}}, x} : {16'h0, x};
    ye = s ? {{16{y[15]}}, y} : {16'h0, y};
    return xe * ye;
  endfunction

  task automatic op6(input logic [5:0] x, input logic [5:0] y, input logic s,
                     input logic [11:0] exp, input string tag);
    int n;
    n = 0;
    while (!ir6 && n < 50) begin @(negedge clk); n++; end
    check({tag, " in_ready"}, 64'(ir6), 64'd1);
    a6 = x; b6 = y; s6 = s; iv6 = 1'b1; or6 = 1'b1;
    @(negedge clk);
    iv6 = 1'b0; a6 = 6'($urandom); b6 = 6'($urandom); s6 = ~s;
    n = 0;
    while (!ov6 && n < 50) begin @(negedge clk); n++; end
    check({tag, " latency"}, 64'(n), 64'd7);
    check({tag, " product"}, 64'(p6), 64'(exp));
    check({tag, " ready_low"}, 64'(ir6), 64'd0);
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                      input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (!ir16 && n < 50) begin @(negedge clk); n++; end
    check({tag, " in_ready"}, 64'(ir16), 64'd1);
    a16 = x; b16 = y; s16 = s; iv16 = 1'b1; or16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (!ov16 && n < 50) begin @(negedge clk); n++; end
    check({tag, " latency"}, 64'(n), 64'd17);
    check({tag, " product"}, 64'(p16), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    rst = 1'b1;
    iv6 = 1'b0; a6 = '0; b6 = '0; s6 = 1'b0; or6 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; or16 = 1'b1;

    #1;
    check("rst in_ready", 64'(ir6), 64'd0);
    check("rst out_valid", 64'(ov6), 64'd0);
    check("rst product", 64'(p6), 64'd0);
    check("rst in_ready16", 64'(ir16), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 64'(ir6), 64'd1);
    check("post-rst out_valid", 64'(ov6), 64'd0);
    @(negedge clk);

    op6(6'd5,  6'd3,  1'b0, 12'h00F, "u 5x3");
    op6(6'd63, 6'd63, 1'b0, 12'hF81, "u 63x63");
    op6(6'd0,  6'd0,  1'b0, 12'h000, "u 0x0");
    op6(6'h3F, 6'h3F, 1'b1, 12'h001, "s -1x-1");
    op6(6'h20, 6'h20, 1'b1, 12'h400, "s -32x-32");
    op6(6'h20, 6'h1F, 1'b1, 12'hC20, "s -32x31");
    op6(6'd25, 6'd19, 1'b1, 12'h1DB, "s 25x19");

    // Backpressure: hold out_ready low for 5 cycles while pushing ignored operands.
    a6 = 6'd7; b6 = 6'd5; s6 = 1'b0; iv6 = 1'b1; or6 = 1'b0;
    @(negedge clk);
    iv6 = 1'b0;
    n = 0;
    while (!ov6 && n < 50) begin @(negedge clk); n++; end
    check("bp first product", 64'(p6), 64'h023);
    for (int i = 0; i < 5; i++) begin
      iv6 = 1'b1; a6 = 6'h3F; b6 = 6'h3F; s6 = 1'b1;
      @(negedge clk);
      check("bp out_valid held", 64'(ov6), 64'd1);
      check("bp in_ready low", 64'(ir6), 64'd0);
      check("bp product stable", 64'(p6), 64'h023);
    end
    iv6 = 1'b0; or6 = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 64'(ov6), 64'd0);
    check("bp release in_ready", 64'(ir6), 64'd1);
    check("bp product kept", 64'(p6), 64'h023);
    op6(6'd12, 6'd11, 1'b0, 12'h084, "u 12x11 after bp");

    // Reset during the third RUN cycle of 9x6.
    a6 = 6'd9; b6 = 6'd6; s6 = 1'b0; iv6 = 1'b1;
    @(negedge clk);
    iv6 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-run rst out_valid", 64'(ov6), 64'd0);
    check("mid-run rst product", 64'(p6), 64'd0);
    check("mid-run rst in_ready", 64'(ir6), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid-run rst recover", 64'(ir6), 64'd1);
    check("mid-run rst no valid", 64'(ov6), 64'd0);
    op6(6'd9, 6'd6, 1'b0, 12'h036, "u 9x6 after rst");

    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u16 max");
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s16 min^2");
    op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "s16 min*max");

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        op16(ra, rb, m[0], ref16(ra, rb, m[0]), m[0] ? "rnd s16" : "rnd u16");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  always @(negedge clk) begin
    if (ir6 && ov6) begin
      failed++;
      $display("FAIL ready_valid_overlap: in_ready %0d out_valid %0d", ir6, ov6);
    end
  end

endmodule
